// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: drains NUM_IN upstream FIFOs in round-robin order into a
// single downstream FIFO, tagging each word with its source index.
// Pop-to-push latency is two cycles: the pop cycle, then the cycle in which
// the upstream read data is captured. The push is visible the cycle after that.
// Optional feature macro: ARB_WORD_COUNT_EN adds count_clr / word_count.
module fifo_rr_arbiter #(
   parameter int WORD_SIZE = 6,
   parameter int NUM_IN    = 4,
   parameter int IDX_W     = 2
) (
   input  logic                          clk,
   input  logic                          reset_L,
   input  logic [NUM_IN*WORD_SIZE-1:0]   in_data,
   input  logic [NUM_IN-1:0]             in_empty,
   output logic [NUM_IN-1:0]             in_pop,
   input  logic                          out_almost_full,
   output logic                          out_push,
   output logic [WORD_SIZE-1:0]          out_data,
   output logic [IDX_W-1:0]              out_src,
   output logic                          idle,
   output logic [1:0]                    state
`ifdef ARB_WORD_COUNT_EN
   ,
   input  logic                          count_clr,
   output logic [15:0]                   word_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_STALL  = 2'b10
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 pop_q, pop_d;
   logic [IDX_W-1:0]     pop_src_q, pop_src_d;
   logic                 out_push_q, out_push_d;
   logic [WORD_SIZE-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]     out_src_q, out_src_d;

   logic                 any_ready;
   logic                 pop_en;
   logic                 grant_vld;
   logic [IDX_W-1:0]     grant_idx;
   logic [WORD_SIZE-1:0] in_word [NUM_IN];

   assign any_ready = ~(&in_empty);

   // Unpack the flat upstream data bus into per-input words
   always_comb begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         in_word[i] = in_data[i*WORD_SIZE +: WORD_SIZE];
      end
   end

   // Round-robin search: first non-empty input at or above rr_ptr, wrapping
   always_comb begin
      logic [IDX_W-1:0] cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         cand = rr_ptr_q + IDX_W'(k);
         if (!grant_vld && !in_empty[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // FSM next state and pop enable; pops happen only in ACTIVE with room downstream
   always_comb begin
      state_d = state_q;
      pop_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_ready && !out_almost_full) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (out_almost_full)  state_d = ST_STALL;
            else if (!any_ready)  state_d = ST_IDLE;
            else                  pop_en  = grant_vld;
         end
         ST_STALL: begin
            if (!out_almost_full) state_d = any_ready ? ST_ACTIVE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pop strobe, pointer advance and the two-stage push pipeline
   always_comb begin
      in_pop     = '0;
      rr_ptr_d   = rr_ptr_q;
      pop_d      = pop_en;
      pop_src_d  = pop_src_q;
      if (pop_en) begin
         in_pop[grant_idx] = 1'b1;
         rr_ptr_d          = grant_idx + IDX_W'(1);
         pop_src_d         = grant_idx;
      end
      // Upstream data for a pop appears one cycle later; capture it then
      out_push_d = pop_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      if (pop_q) begin
         out_data_d = in_word[pop_src_q];
         out_src_d  = pop_src_q;
      end
   end

   // State and pipeline registers; reset drops any word still in flight
   always_ff @(posedge clk or posedge reset_L) begin
      if (reset_L) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         pop_q      <= 1'b0;
         pop_src_q  <= '0;
         out_push_q <= 1'b0;
         out_data_q <= '0;
         out_src_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         pop_q      <= pop_d;
         pop_src_q  <= pop_src_d;
         out_push_q <= out_push_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
      end
   end

   // pop_q / out_push_q cover pops issued one and two cycles ago
   assign idle     = (state_q == ST_IDLE) && (&in_empty) && !pop_q && !out_push_q;
   assign state    = state_q;
   assign out_push = out_push_q;
   assign out_data = out_data_q;
   assign out_src  = out_src_q;

`ifdef ARB_WORD_COUNT_EN
   logic [15:0] word_count_q, word_count_d;

   // Forwarded-word counter; clear has priority over a same-cycle push
   always_comb begin
      word_count_d = word_count_q;
      if (count_clr)       word_count_d = '0;
      else if (out_push_q) word_count_d = word_count_q + 16'd1;
   end

   // Counter register
   always_ff @(posedge clk or posedge reset_L) begin
      if (reset_L) word_count_q <= '0;
      else         word_count_q <= word_count_d;
   end

   assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: upstream FIFOs are queues, the reference model
// predicts grants, push timing/data and state from the arbitration rules.
module tb_fifo_rr_arbiter;
   localparam int W  = 6;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int DW = N * W;
   localparam int S_IDLE  = 0;
   localparam int S_ACT   = 1;
   localparam int S_STALL = 2;

   logic          clk = 1'b0;
   logic          reset_L;
   logic [DW-1:0] in_data;
   logic [N-1:0]  in_empty;
   logic [N-1:0]  in_pop;
   logic          out_almost_full;
   logic          out_push;
   logic [W-1:0]  out_data;
   logic [IW-1:0] out_src;
   logic          idle;
   logic [1:0]    state;
`ifdef ARB_WORD_COUNT_EN
   logic          count_clr;
   logic [15:0]   word_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [W-1:0] fq [N][$];
   logic [W-1:0] exp_d [$];
   int           exp_s [$];
   int           exp_t [$];
   int           pop_idx [$];
   int           pop_cyc [$];
   int           push_src [$];
   int           push_cyc [$];
   int           cyc = 0;
   int           ptr = 0;
   int           exp_state = S_IDLE;
   int           last_pop_cyc = -100;
   logic [W-1:0] last_d = '0;
   int           last_s = 0;

   always #5 clk = ~clk;

   fifo_rr_arbiter #(
      .WORD_SIZE(W),
      .NUM_IN(N),
      .IDX_W(IW)
   ) dut (
      .clk(clk),
      .reset_L(reset_L),
      .in_data(in_data),
      .in_empty(in_empty),
      .in_pop(in_pop),
      .out_almost_full(out_almost_full),
      .out_push(out_push),
      .out_data(out_data),
      .out_src(out_src),
      .idle(idle),
      .state(state)
`ifdef ARB_WORD_COUNT_EN
      ,
      .count_clr(count_clr),
      .word_count(word_count)
`endif
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic upd();
      for (int i = 0; i < N; i++) in_empty[i] = (fq[i].size() == 0);
   endtask

   task automatic model_reset();
      exp_state = S_IDLE; ptr = 0; last_pop_cyc = -100; last_d = '0; last_s = 0;
      exp_d.delete(); exp_s.delete(); exp_t.delete();
      pop_idx.delete(); pop_cyc.delete(); push_src.delete(); push_cyc.delete();
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) fq[i].delete();
      in_empty = '1; out_almost_full = 1'b0; in_data = '0;
`ifdef ARB_WORD_COUNT_EN
      count_clr = 1'b0;
`endif
      reset_L = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_L = 1'b0;
      model_reset();
   endtask

   // One clock: compare at negedge against the model, then act as upstream FIFOs
   task automatic tick(input logic af_next, input int fill_pct);
      logic         any, popping, due, exp_idle, pres_v;
      logic [N-1:0] exp_pop;
      logic [W-1:0] pres_w;
      int           eg, pres_i, ns;
      @(negedge clk);
      any = (in_empty != '1);
      n_chk++;
      if (state !== 2'(exp_state)) begin
         n_fail++; $display("FAIL state @%0d: got %b expected %b", cyc, state, 2'(exp_state));
      end
      exp_idle = (exp_state == S_IDLE) && !any && (cyc - last_pop_cyc > 2);
      n_chk++;
      if (idle !== exp_idle) begin
         n_fail++; $display("FAIL idle @%0d: got %b expected %b", cyc, idle, exp_idle);
      end
      popping = (exp_state == S_ACT) && !out_almost_full && any;
      exp_pop = '0;
      if (popping) begin
         eg = -1;
         for (int k = 0; k < N; k++)
            if (eg < 0 && !in_empty[(ptr + k) % N]) eg = (ptr + k) % N;
         exp_pop[eg] = 1'b1;
         exp_d.push_back(fq[eg][0]); exp_s.push_back(eg); exp_t.push_back(cyc + 2);
         ptr = (eg + 1) % N;
         last_pop_cyc = cyc;
      end
      n_chk++;
      if (in_pop !== exp_pop) begin
         n_fail++; $display("FAIL in_pop @%0d: got %b expected %b", cyc, in_pop, exp_pop);
      end
      pres_v = 1'b0; pres_i = 0; pres_w = '0;
      for (int i = 0; i < N; i++) begin
         if (in_pop[i] === 1'b1) begin
            pop_idx.push_back(i); pop_cyc.push_back(cyc);
            if (fq[i].size() > 0) begin pres_v = 1'b1; pres_i = i; pres_w = fq[i].pop_front(); end
         end
      end
      due = (exp_t.size() > 0) && (exp_t[0] == cyc);
      n_chk++;
      if (out_push !== due) begin
         n_fail++; $display("FAIL out_push @%0d: got %b expected %b", cyc, out_push, due);
      end
      if (due) begin
         n_chk++;
         if (out_data !== exp_d[0] || out_src !== IW'(exp_s[0])) begin
            n_fail++; $display("FAIL push_word @%0d: got %h/src %0d expected %h/src %0d",
                               cyc, out_data, out_src, exp_d[0], exp_s[0]);
         end
         last_d = exp_d.pop_front(); last_s = exp_s.pop_front(); void'(exp_t.pop_front());
      end else begin
         n_chk++;
         if (out_data !== last_d || out_src !== IW'(last_s)) begin
            n_fail++; $display("FAIL hold @%0d: got %h/src %0d expected %h/src %0d",
                               cyc, out_data, out_src, last_d, last_s);
         end
      end
      if (out_push === 1'b1) begin push_src.push_back(int'(out_src)); push_cyc.push_back(cyc); end
      case (exp_state)
         S_IDLE:  ns = (any && !out_almost_full) ? S_ACT : S_IDLE;
         S_ACT:   ns = out_almost_full ? S_STALL : (any ? S_ACT : S_IDLE);
         default: ns = out_almost_full ? S_STALL : (any ? S_ACT : S_IDLE);
      endcase
      exp_state = ns;
      @(posedge clk);
      cyc++;
      #1;
      in_data = DW'($urandom);
      if (pres_v) in_data[pres_i*W +: W] = pres_w;
      for (int i = 0; i < N; i++)
         if (fq[i].size() < 8 && int'($urandom_range(0, 99)) < fill_pct) fq[i].push_back(W'($urandom));
      upd();
      out_almost_full = af_next;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if (out_data !== '0 || out_src !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h/%0d expected 0/0", out_data, out_src);
      end
      for (int c = 0; c < 10; c++) begin
         tick(1'b0, 0);
         n_chk++;
         if (idle !== 1'b1 || state !== 2'b00 || in_pop !== 4'b0000 || out_push !== 1'b0) begin
            n_fail++; $display("FAIL reset_quiet c%0d: got idle=%b state=%b pop=%b push=%b expected 1/00/0000/0",
                               c, idle, state, in_pop, out_push);
         end
      end
   endtask

   task automatic test_alternate();
      do_reset();
      for (int k = 0; k < 3; k++) begin fq[0].push_back(W'($urandom)); fq[2].push_back(W'($urandom)); end
      upd();
      repeat (12) tick(1'b0, 0);
      n_chk++;
      if (pop_idx.size() != 6 || push_src.size() != 6) begin
         n_fail++; $display("FAIL alt_count: got pops=%0d pushes=%0d expected 6/6", pop_idx.size(), push_src.size());
      end
      for (int k = 0; k < 6; k++) begin
         if (k < pop_idx.size() && k < push_src.size()) begin
            n_chk++;
            if (pop_idx[k] != (k % 2) * 2 || push_src[k] != (k % 2) * 2 || push_cyc[k] - pop_cyc[k] != 2) begin
               n_fail++; $display("FAIL alt_order k%0d: got pop %0d src %0d lat %0d expected %0d/%0d/2",
                                  k, pop_idx[k], push_src[k], push_cyc[k] - pop_cyc[k], (k % 2) * 2, (k % 2) * 2);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) for (int k = 0; k < 12; k++) fq[i].push_back(W'($urandom));
      upd();
      repeat (9) tick(1'b0, 0);
      n_chk++;
      if (pop_idx.size() < 8) begin
         n_fail++; $display("FAIL rr_count: got %0d pops expected >= 8", pop_idx.size());
      end
      for (int k = 0; k < 8; k++) begin
         if (k < pop_idx.size()) begin
            n_chk++;
            if (pop_idx[k] != k % N || pop_cyc[k] != pop_cyc[0] + k) begin
               n_fail++; $display("FAIL rr_order k%0d: got input %0d at +%0d expected input %0d at +%0d",
                                  k, pop_idx[k], pop_cyc[k] - pop_cyc[0], k % N, k);
            end
         end
      end
   endtask

   task automatic test_stall();
      int n0, np, last;
      do_reset();
      for (int i = 0; i < N; i++) for (int k = 0; k < 10; k++) fq[i].push_back(W'($urandom));
      upd();
      repeat (4) tick(1'b0, 0);
      tick(1'b1, 0);
      n0 = push_src.size(); np = pop_idx.size();
      last = (np > 0) ? pop_idx[np-1] : -1;
      tick(1'b1, 0);
      n_chk++;
      if (state !== 2'b10 || in_pop !== '0) begin
         n_fail++; $display("FAIL stall_state: got state=%b pop=%b expected 10/0000", state, in_pop);
      end
      repeat (2) tick(1'b1, 0);
      repeat (2) tick(1'b0, 0);
      n_chk++;
      if (push_src.size() - n0 != 2 || pop_idx.size() != np) begin
         n_fail++; $display("FAIL stall_inflight: got pushes=%0d pops=%0d expected 2/0",
                            push_src.size() - n0, pop_idx.size() - np);
      end
      repeat (3) tick(1'b0, 0);
      n_chk++;
      if (pop_idx.size() <= np || pop_idx[np] != (last + 1) % N) begin
         n_fail++; $display("FAIL stall_resume: got first pop %0d expected %0d",
                            (pop_idx.size() > np) ? pop_idx[np] : -1, (last + 1) % N);
      end
   endtask

   task automatic test_reset_midflight();
      int guard;
      do_reset();
      fq[1].push_back(6'h2A); upd();
      repeat (5) tick(1'b0, 0);
      fq[2].push_back(6'h15); upd();
      guard = 0;
      while (pop_idx.size() < 2 && guard < 6) begin tick(1'b0, 0); guard++; end
      n_chk++;
      if (pop_idx.size() < 2) begin
         n_fail++; $display("FAIL mid_pop_timeout: got %0d pops expected 2", pop_idx.size());
      end
      reset_L = 1'b1;
      #1;
      n_chk++;
      if (in_pop !== '0 || out_push !== 1'b0 || out_data !== '0 || out_src !== '0 || state !== 2'b00 || idle !== 1'b1) begin
         n_fail++; $display("FAIL async_reset: got pop=%b push=%b data=%h src=%0d state=%b idle=%b expected all reset values",
                            in_pop, out_push, out_data, out_src, state, idle);
      end
      @(posedge clk);
      #1 reset_L = 1'b0;
      model_reset();
      repeat (6) tick(1'b0, 0);
      n_chk++;
      if (push_src.size() != 0) begin
         n_fail++; $display("FAIL dropped_word: got %0d pushes expected 0", push_src.size());
      end
      for (int i = 0; i < N; i++) fq[i].push_back(W'($urandom));
      upd();
      repeat (3) tick(1'b0, 0);
      n_chk++;
      if (pop_idx.size() == 0 || pop_idx[0] != 0) begin
         n_fail++; $display("FAIL ptr_after_reset: got %0d expected 0", (pop_idx.size() > 0) ? pop_idx[0] : -1);
      end
   endtask

   task automatic test_random();
      logic af_mode;
      int   fill;
      do_reset();
      af_mode = 1'b0; fill = 30;
      for (int c = 0; c < 600; c++) begin
         if (c % 100 == 0) fill = $urandom_range(5, 80);
         if ($urandom_range(0, 99) < 10) af_mode = !af_mode;
         tick(af_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0), fill);
      end
      repeat (80) tick(1'b0, 0);
      n_chk++;
      if (exp_t.size() != 0 || in_empty !== '1) begin
         n_fail++; $display("FAIL random_drain: got %0d pending, empty=%b expected 0/1111", exp_t.size(), in_empty);
      end
   endtask

`ifdef ARB_WORD_COUNT_EN
   task automatic test_word_count();
      do_reset();
      n_chk++;
      if (word_count !== 16'd0) begin
         n_fail++; $display("FAIL wc_reset: got %0d expected 0", word_count);
      end
      for (int k = 0; k < 3; k++) fq[0].push_back(W'($urandom));
      for (int k = 0; k < 2; k++) fq[1].push_back(W'($urandom));
      upd();
      repeat (10) tick(1'b0, 0);
      n_chk++;
      if (word_count !== 16'd5) begin
         n_fail++; $display("FAIL wc_five: got %0d expected 5", word_count);
      end
      count_clr = 1'b1;
      fq[3].push_back(W'($urandom)); upd();
      repeat (5) tick(1'b0, 0);
      count_clr = 1'b0;
      n_chk++;
      if (word_count !== 16'd0 || push_src.size() != 6) begin
         n_fail++; $display("FAIL wc_clear: got count %0d pushes %0d expected 0/6", word_count, push_src.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alternate();
      test_round_robin();
      test_stall();
      test_reset_midflight();
      test_random();
`ifdef ARB_WORD_COUNT_EN
      test_word_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
